id_ex_operand_stage: RTL and testbench

//  ID/EX pipeline register plus EX operand resolution, directly upstream of the ALU.

---
 rtl/id_ex_operand_stage.sv | 173 +++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with load-use bubble insertion
// and EX-stage operand forwarding, sitting directly in front of the ALU.
// Optional build macro IDEX_PERF_CNT_EN adds bubble and flush event counters.
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_addr_i,
  input  logic [REG_AW-1:0] id_rs2_addr_i,
  input  logic [REG_AW-1:0] id_rd_addr_i,
  input  logic [DATA_W-1:0] id_rs1_data_i,
  input  logic [DATA_W-1:0] id_rs2_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic              id_alusrc_i,
  input  logic [CTRL_W-1:0] id_aluctrl_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              id_memwrite_i,
  input  logic              id_memtoreg_i,
  input  logic              exmem_regwrite_i,
  input  logic [REG_AW-1:0] exmem_rd_addr_i,
  input  logic [DATA_W-1:0] exmem_data_i,
  input  logic              memwb_regwrite_i,
  input  logic [REG_AW-1:0] memwb_rd_addr_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic              hazard_stall_o,
  output logic [DATA_W-1:0] alu_data0_o,
  output logic [DATA_W-1:0] alu_data1_o,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  output logic [DATA_W-1:0] ex_store_data_o,
  output logic              ex_valid_o,
  output logic [REG_AW-1:0] ex_rd_addr_o,
  output logic              ex_regwrite_o,
  output logic              ex_memread_o,
  output logic              ex_memwrite_o,
  output logic              ex_memtoreg_o
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [31:0]       bubble_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              alusrc;
    logic [CTRL_W-1:0] ctrl;
    logic [REG_AW-1:0] rd_addr;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
  } ex_reg_t;

  ex_reg_t           ex_q, ex_d;
  logic              hazard;
  logic [DATA_W-1:0] fwd_rs1, fwd_rs2;

  // Load-use hazard: a load in EX whose destination an ID source still needs.
  always_comb begin
    hazard = ex_q.valid && ex_q.memread && (ex_q.rd_addr != '0) && id_valid_i &&
             ((ex_q.rd_addr == id_rs1_addr_i) || (ex_q.rd_addr == id_rs2_addr_i));
    hazard_stall_o = hazard && !rst_i;
  end

  // Next EX register: a flush kills, a stall holds, a hazard kills, otherwise load ID.
  always_comb begin
    ex_d = ex_q;
    if (flush_i || (!stall_i && hazard)) begin
      ex_d.valid    = 1'b0;
      ex_d.regwrite = 1'b0;
      ex_d.memread  = 1'b0;
      ex_d.memwrite = 1'b0;
      ex_d.memtoreg = 1'b0;
    end else if (!stall_i) begin
      ex_d.valid    = id_valid_i;
      ex_d.regwrite = id_regwrite_i;
      ex_d.memread  = id_memread_i;
      ex_d.memwrite = id_memwrite_i;
      ex_d.memtoreg = id_memtoreg_i;
      ex_d.alusrc   = id_alusrc_i;
      ex_d.ctrl     = id_aluctrl_i;
      ex_d.rd_addr  = id_rd_addr_i;
      ex_d.rs1_addr = id_rs1_addr_i;
      ex_d.rs2_addr = id_rs2_addr_i;
      ex_d.rs1_data = id_rs1_data_i;
      ex_d.rs2_data = id_rs2_data_i;
      ex_d.imm      = id_imm_i;
    end
  end

  // ID/EX register; reset clears everything, which reads as an AND bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // Forwarding per source: EX/MEM beats MEM/WB, and x0 is never forwarded.
  always_comb begin
    fwd_rs1 = ex_q.rs1_data;
    if (exmem_regwrite_i && (exmem_rd_addr_i != '0) && (exmem_rd_addr_i == ex_q.rs1_addr)) begin
      fwd_rs1 = exmem_data_i;
    end else if (memwb_regwrite_i && (memwb_rd_addr_i != '0) && (memwb_rd_addr_i == ex_q.rs1_addr)) begin
      fwd_rs1 = memwb_data_i;
    end
    fwd_rs2 = ex_q.rs2_data;
    if (exmem_regwrite_i && (exmem_rd_addr_i != '0) && (exmem_rd_addr_i == ex_q.rs2_addr)) begin
      fwd_rs2 = exmem_data_i;
    end else if (memwb_regwrite_i && (memwb_rd_addr_i != '0) && (memwb_rd_addr_i == ex_q.rs2_addr)) begin
      fwd_rs2 = memwb_data_i;
    end
  end

  // ALU operands and EX controls; stores always take the forwarded rs2.
  always_comb begin
    alu_data0_o     = fwd_rs1;
    alu_data1_o     = ex_q.alusrc ? ex_q.imm : fwd_rs2;
    ex_store_data_o = fwd_rs2;
    alu_ctrl_o      = ex_q.ctrl;
    ex_valid_o      = ex_q.valid;
    ex_rd_addr_o    = ex_q.rd_addr;
    ex_regwrite_o   = ex_q.regwrite;
    ex_memread_o    = ex_q.memread;
    ex_memwrite_o   = ex_q.memwrite;
    ex_memtoreg_o   = ex_q.memtoreg;
  end

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Count hazard bubbles actually loaded and every flush cycle; both wrap.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (!flush_i && !stall_i && hazard) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
    if (flush_i) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bubble_cnt_o = bubble_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: table of single-instruction vectors checked through
// an expected-value queue, plus hand sequences for reset, load-use stalls,
// stall/flush interaction and the optional perf counters.
module tb_id_ex_operand_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        id_valid_i = 1'b0;
  logic [4:0]  id_rs1_addr_i = '0, id_rs2_addr_i = '0, id_rd_addr_i = '0;
  logic [31:0] id_rs1_data_i = '0, id_rs2_data_i = '0, id_imm_i = '0;
  logic        id_alusrc_i = 1'b0;
  logic [3:0]  id_aluctrl_i = '0;
  logic        id_regwrite_i = 1'b0, id_memread_i = 1'b0, id_memwrite_i = 1'b0, id_memtoreg_i = 1'b0;
  logic        exmem_regwrite_i = 1'b0;
  logic [4:0]  exmem_rd_addr_i = '0;
  logic [31:0] exmem_data_i = '0;
  logic        memwb_regwrite_i = 1'b0;
  logic [4:0]  memwb_rd_addr_i = '0;
  logic [31:0] memwb_data_i = '0;
  logic        hazard_stall_o;
  logic [31:0] alu_data0_o, alu_data1_o, ex_store_data_o;
  logic [3:0]  alu_ctrl_o;
  logic        ex_valid_o;
  logic [4:0]  ex_rd_addr_o;
  logic        ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0] bubble_cnt_o, flush_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  id_ex_operand_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rd_addr_i(id_rd_addr_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_alusrc_i(id_alusrc_i), .id_aluctrl_i(id_aluctrl_i),
    .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i), .id_memwrite_i(id_memwrite_i),
    .id_memtoreg_i(id_memtoreg_i), .exmem_regwrite_i(exmem_regwrite_i),
    .exmem_rd_addr_i(exmem_rd_addr_i), .exmem_data_i(exmem_data_i),
    .memwb_regwrite_i(memwb_regwrite_i), .memwb_rd_addr_i(memwb_rd_addr_i),
    .memwb_data_i(memwb_data_i), .hazard_stall_o(hazard_stall_o),
    .alu_data0_o(alu_data0_o), .alu_data1_o(alu_data1_o), .alu_ctrl_o(alu_ctrl_o),
    .ex_store_data_o(ex_store_data_o), .ex_valid_o(ex_valid_o), .ex_rd_addr_o(ex_rd_addr_o),
    .ex_regwrite_o(ex_regwrite_o), .ex_memread_o(ex_memread_o),
    .ex_memwrite_o(ex_memwrite_o), .ex_memtoreg_o(ex_memtoreg_o)
`ifdef IDEX_PERF_CNT_EN
    , .bubble_cnt_o(bubble_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  // Free-running clock, period 10.
  always #5 clk_i = ~clk_i;

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct packed {
    logic [4:0]  rs1_a;
    logic [31:0] rs1_d;
    logic [4:0]  rs2_a;
    logic [31:0] rs2_d;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        alusrc;
    logic [3:0]  ctrl;
    logic        regw;
    logic        memw;
    logic        exw;
    logic [4:0]  exrd;
    logic [31:0] exd;
    logic        wbw;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic [31:0] exp_d0;
    logic [31:0] exp_d1;
    logic [31:0] exp_st;
  } vec_t;

  typedef struct packed {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] st;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        regw;
    logic        memw;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  vec_t cur;

  function automatic vec_t mk(
    input logic [4:0] rs1_a, input logic [31:0] rs1_d, input logic [4:0] rs2_a,
    input logic [31:0] rs2_d, input logic [4:0] rd, input logic [31:0] imm,
    input logic alusrc, input logic [3:0] ctrl, input logic regw, input logic memw,
    input logic exw, input logic [4:0] exrd, input logic [31:0] exd,
    input logic wbw, input logic [4:0] wbrd, input logic [31:0] wbd,
    input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] es);
    vec_t v;
    v.rs1_a = rs1_a; v.rs1_d = rs1_d; v.rs2_a = rs2_a; v.rs2_d = rs2_d;
    v.rd = rd; v.imm = imm; v.alusrc = alusrc; v.ctrl = ctrl;
    v.regw = regw; v.memw = memw;
    v.exw = exw; v.exrd = exrd; v.exd = exd;
    v.wbw = wbw; v.wbrd = wbrd; v.wbd = wbd;
    v.exp_d0 = e0; v.exp_d1 = e1; v.exp_st = es;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic driveId(input logic valid, input logic [4:0] rs1_a, input logic [31:0] rs1_d,
                         input logic [4:0] rs2_a, input logic [31:0] rs2_d, input logic [4:0] rd,
                         input logic [31:0] imm, input logic alusrc, input logic [3:0] ctrl,
                         input logic regw, input logic memr, input logic memw, input logic m2r);
    id_valid_i = valid; id_rs1_addr_i = rs1_a; id_rs1_data_i = rs1_d;
    id_rs2_addr_i = rs2_a; id_rs2_data_i = rs2_d; id_rd_addr_i = rd;
    id_imm_i = imm; id_alusrc_i = alusrc; id_aluctrl_i = ctrl;
    id_regwrite_i = regw; id_memread_i = memr; id_memwrite_i = memw; id_memtoreg_i = m2r;
  endtask

  task automatic clearFwd();
    exmem_regwrite_i = 1'b0; exmem_rd_addr_i = '0; exmem_data_i = '0;
    memwb_regwrite_i = 1'b0; memwb_rd_addr_i = '0; memwb_data_i = '0;
  endtask

  // Drive one vector into ID, queue its expectation, then present the forwarding state.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clk_i);
    driveId(1'b1, v.rs1_a, v.rs1_d, v.rs2_a, v.rs2_d, v.rd, v.imm, v.alusrc, v.ctrl,
            v.regw, 1'b0, v.memw, 1'b0);
    clearFwd();
    e.d0 = v.exp_d0; e.d1 = v.exp_d1; e.st = v.exp_st; e.ctrl = v.ctrl;
    e.rd = v.rd; e.regw = v.regw; e.memw = v.memw;
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    exmem_regwrite_i = v.exw; exmem_rd_addr_i = v.exrd; exmem_data_i = v.exd;
    memwb_regwrite_i = v.wbw; memwb_rd_addr_i = v.wbrd; memwb_data_i = v.wbd;
  endtask

  // Pop the oldest expectation and compare against the EX outputs.
  task automatic checkOutput(input int idx);
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard[%0d]: got empty queue expected entry", idx);
    end else begin
      e = exp_q.pop_front();
      checkVal($sformatf("data0[%0d]", idx), alu_data0_o, e.d0);
      checkVal($sformatf("data1[%0d]", idx), alu_data1_o, e.d1);
      checkVal($sformatf("store[%0d]", idx), ex_store_data_o, e.st);
      checkVal($sformatf("ctrl[%0d]", idx), {28'd0, alu_ctrl_o}, {28'd0, e.ctrl});
      checkVal($sformatf("rd[%0d]", idx), {27'd0, ex_rd_addr_o}, {27'd0, e.rd});
      checkVal($sformatf("valid[%0d]", idx), {31'd0, ex_valid_o}, 32'd1);
      checkVal($sformatf("regwrite[%0d]", idx), {31'd0, ex_regwrite_o}, {31'd0, e.regw});
      checkVal($sformatf("memwrite[%0d]", idx), {31'd0, ex_memwrite_o}, {31'd0, e.memw});
      checkVal($sformatf("hazard[%0d]", idx), {31'd0, hazard_stall_o}, 32'd0);
    end
  endtask

  initial begin
    //            rs1 rs1_d        rs2 rs2_d   rd  imm           as ctrl  rw mw  exw exrd exd       wbw wbrd wbd      d0            d1            st
    vecs.push_back(mk(1, 32'h5,    2, 32'h7,   3, 32'h0,        0, 4'h3, 1, 0,  0, 0,  32'h0,    0, 0,  32'h0,    32'h5,        32'h7,        32'h7));
    vecs.push_back(mk(1, 32'h99,   2, 32'h7,   3, 32'h0,        0, 4'h3, 1, 0,  1, 1,  32'h10,   1, 1,  32'h20,   32'h10,       32'h7,        32'h7));
    vecs.push_back(mk(1, 32'h99,   2, 32'h7,   3, 32'h0,        0, 4'h3, 1, 0,  1, 0,  32'h10,   1, 0,  32'h20,   32'h99,       32'h7,        32'h7));
    vecs.push_back(mk(1, 32'h99,   2, 32'h7,   3, 32'h0,        0, 4'h4, 1, 0,  0, 1,  32'h10,   1, 1,  32'h20,   32'h20,       32'h7,        32'h7));
    vecs.push_back(mk(7, 32'hA,    6, 32'h1,   9, 32'hFFFFFFFF, 1, 4'h6, 1, 0,  1, 6,  32'h33,   0, 0,  32'h0,    32'hA,        32'hFFFFFFFF, 32'h33));
    vecs.push_back(mk(11, 32'h2,   8, 32'h3,   0, 32'h4,        1, 4'h3, 0, 1,  1, 9,  32'h11,   1, 8,  32'h44,   32'h2,        32'h4,        32'h44));
    vecs.push_back(mk(10, 32'h1,  10, 32'h2,  12, 32'h0,        0, 4'h5, 1, 0,  1, 10, 32'h55,   1, 10, 32'h66,   32'h55,       32'h55,       32'h55));
    vecs.push_back(mk(0, 32'h0,   13, 32'hC,  14, 32'h0,        0, 4'h8, 1, 0,  1, 0,  32'h77,   1, 0,  32'h78,   32'h0,        32'hC,        32'hC));

    // Reset: hold two cycles with a dependent instruction waiting in ID.
    driveId(1'b1, 5'd4, 32'h1, 5'd4, 32'h1, 5'd5, 32'h0, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    checkVal("reset_valid", {31'd0, ex_valid_o}, 32'd0);
    checkVal("reset_ctrl", {28'd0, alu_ctrl_o}, 32'd0);
    checkVal("reset_data0", alu_data0_o, 32'd0);
    checkVal("reset_hazard", {31'd0, hazard_stall_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      cur = vecs[i];
      applyStimulus(cur);
      checkOutput(i);
    end

    // Load-use: lw x4 in EX, dependent ADD in ID gets one bubble then MEM/WB data.
    @(negedge clk_i);
    clearFwd();
    driveId(1'b1, 5'd2, 32'h100, 5'd0, 32'h0, 5'd4, 32'h8, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk_i); #1;
    checkVal("lw_memread", {31'd0, ex_memread_o}, 32'd1);
    checkVal("lw_memtoreg", {31'd0, ex_memtoreg_o}, 32'd1);
    driveId(1'b1, 5'd4, 32'hDEAD, 5'd4, 32'hDEAD, 5'd5, 32'h0, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checkVal("lu_hazard", {31'd0, hazard_stall_o}, 32'd1);
    @(posedge clk_i); #1;
    checkVal("lu_bubble_valid", {31'd0, ex_valid_o}, 32'd0);
    checkVal("lu_bubble_regwrite", {31'd0, ex_regwrite_o}, 32'd0);
    checkVal("lu_bubble_memread", {31'd0, ex_memread_o}, 32'd0);
    checkVal("lu_hazard_clear", {31'd0, hazard_stall_o}, 32'd0);
    @(posedge clk_i); #1;
    memwb_regwrite_i = 1'b1; memwb_rd_addr_i = 5'd4; memwb_data_i = 32'hCAFE;
    #1;
    checkVal("lu_add_data0", alu_data0_o, 32'hCAFE);
    checkVal("lu_add_data1", alu_data1_o, 32'hCAFE);
    checkVal("lu_add_valid", {31'd0, ex_valid_o}, 32'd1);
    checkVal("lu_add_rd", {27'd0, ex_rd_addr_o}, 32'd5);

    // Hazard during a global stall: EX holds the load until the stall clears.
    clearFwd();
    driveId(1'b1, 5'd2, 32'h100, 5'd0, 32'h0, 5'd6, 32'h8, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk_i); #1;
    driveId(1'b1, 5'd1, 32'h1, 5'd6, 32'h2, 5'd7, 32'h0, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
    stall_i = 1'b1;
    #1;
    checkVal("st_hazard", {31'd0, hazard_stall_o}, 32'd1);
    @(posedge clk_i); #1;
    checkVal("st_hold_valid", {31'd0, ex_valid_o}, 32'd1);
    checkVal("st_hold_memread", {31'd0, ex_memread_o}, 32'd1);
    checkVal("st_hold_rd", {27'd0, ex_rd_addr_o}, 32'd6);
    checkVal("st_hazard_held", {31'd0, hazard_stall_o}, 32'd1);
    stall_i = 1'b0;
    @(posedge clk_i); #1;
    checkVal("st_bubble_valid", {31'd0, ex_valid_o}, 32'd0);
    checkVal("st_hazard_clear", {31'd0, hazard_stall_o}, 32'd0);
`ifdef IDEX_PERF_CNT_EN
    checkVal("bubble_cnt_two", bubble_cnt_o, 32'd2);
    checkVal("flush_cnt_zero", flush_cnt_o, 32'd0);
`endif

    // Invalid ID instruction loads as not valid.
    driveId(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk_i); #1;
    checkVal("idle_valid", {31'd0, ex_valid_o}, 32'd0);

    // Flush with stall and hazard: flush wins and loads a bubble; counters restart from reset.
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    driveId(1'b1, 5'd2, 32'h100, 5'd0, 32'h0, 5'd4, 32'h8, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk_i); #1;
    driveId(1'b1, 5'd4, 32'h1, 5'd3, 32'h2, 5'd5, 32'h0, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
    stall_i = 1'b1;
    flush_i = 1'b1;
    #1;
    checkVal("fl_hazard", {31'd0, hazard_stall_o}, 32'd1);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    stall_i = 1'b0;
    checkVal("fl_valid", {31'd0, ex_valid_o}, 32'd0);
    checkVal("fl_memread", {31'd0, ex_memread_o}, 32'd0);
`ifdef IDEX_PERF_CNT_EN
    checkVal("flush_cnt_one", flush_cnt_o, 32'd1);
    checkVal("bubble_cnt_reset", bubble_cnt_o, 32'd0);
`endif

    // A load to x0 never raises the hazard.
    driveId(1'b1, 5'd2, 32'h100, 5'd0, 32'h0, 5'd0, 32'h8, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk_i); #1;
    driveId(1'b1, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 32'h0, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checkVal("x0_load_hazard", {31'd0, hazard_stall_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
